// File: rtl/serial_byte_collector_pkg.sv
// Shared widths and defaults for the serial byte collector.
package serial_byte_collector_pkg;
   localparam int SER_BYTE_W     = 8;
   localparam int SER_BITCNT_W   = 3;
   localparam int SER_FIFO_DEPTH = 4;

   localparam logic [SER_BITCNT_W-1:0] SER_LAST_BIT = 3'd7;

   // The finished byte is what the upstream shift register will hold after this edge.
   function automatic logic [SER_BYTE_W-1:0] ser_assemble(
      input logic [SER_BYTE_W-1:0] sr,
      input logic                  bit_in
   );
      return {sr[SER_BYTE_W-2:0], bit_in};
   endfunction
endpackage

// File: rtl/serial_byte_collector_fifo.sv
// Small synchronous FIFO; write and pop share one edge, registered level/full/empty.
// rd_data is combinational from the head entry and reads 0 while empty; writes while full need a coincident pop.
module sync_fifo_small #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty,
   output logic         full,
   output logic [AW:0]  level
);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_empty;
   logic          r_full;

   logic          w_pop;
   logic          w_wr;
   logic [AW:0]   w_level_nxt;

   assign w_pop = rd_en && !r_empty;
   assign w_wr  = wr_en && (!r_full || w_pop);

   always_comb begin
      w_level_nxt = r_level;
      if (w_wr && !w_pop)
         w_level_nxt = r_level + 1'b1;
      else if (!w_wr && w_pop)
         w_level_nxt = r_level - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= w_level_nxt;
         r_empty <= (w_level_nxt == '0);
         r_full  <= (w_level_nxt == LVL_FULL);
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr] <= wr_data;
   end

   assign rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
   assign empty   = r_empty;
   assign full    = r_full;
   assign level   = r_level;
endmodule

// File: rtl/serial_byte_collector.sv
// Counts enabled bit slots and pushes each completed byte into a small FIFO, zero extra latency.
// A byte arriving while full is stored only if the host pops on that edge; otherwise it is dropped and overflow sticks.
module serial_byte_collector
   import serial_byte_collector_pkg::*;
#(
   parameter int DEPTH = SER_FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                    inv_serclk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    ser_in,
   input  logic [SER_BYTE_W-1:0]   sr_data,
   input  logic                    frame_clr,
   input  logic                    rd_en,
   output logic [SER_BYTE_W-1:0]   rd_data,
   output logic                    empty,
   output logic                    full,
   output logic [AW:0]             level,
   output logic                    overflow,
   input  logic                    ovf_clr,
   output logic [SER_BITCNT_W-1:0] bit_cnt
);
   logic [SER_BITCNT_W-1:0] r_bit_cnt;
   logic                    r_overflow;

   logic                    w_slot;
   logic                    w_byte_done;
   logic                    w_can_push;
   logic                    w_push;
   logic                    w_drop;
   logic [SER_BYTE_W-1:0]   w_byte;
   logic                    w_unused_sr_msb;

   // frame_clr claims the slot, so a coincident enable is not a counted bit.
   assign w_slot          = enable && !frame_clr;
   assign w_byte_done     = w_slot && (r_bit_cnt == SER_LAST_BIT);
   assign w_byte          = ser_assemble(sr_data, ser_in);
   assign w_unused_sr_msb = sr_data[SER_BYTE_W-1];
   assign w_can_push      = !full || rd_en;
   assign w_push          = w_byte_done && w_can_push;
   assign w_drop          = w_byte_done && !w_can_push;

   always_ff @(posedge inv_serclk or posedge reset) begin
      if (reset) begin
         r_bit_cnt  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (frame_clr)
            r_bit_cnt <= '0;
         else if (enable)
            r_bit_cnt <= r_bit_cnt + 1'b1;
         if (w_drop)
            r_overflow <= 1'b1;
         else if (ovf_clr)
            r_overflow <= 1'b0;
      end
   end

   sync_fifo_small #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (SER_BYTE_W)
   ) u_fifo (
      .clk     (inv_serclk),
      .reset   (reset),
      .wr_en   (w_push),
      .wr_data (w_byte),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .level   (level)
   );

   assign bit_cnt  = r_bit_cnt;
   assign overflow = r_overflow;
endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed and random bit streams against a queue-based model of the collector.
module tb_serial_byte_collector;
   import serial_byte_collector_pkg::*;

   localparam int DEPTH = SER_FIFO_DEPTH;
   localparam int AW    = $clog2(DEPTH);

   logic        inv_serclk;
   logic        reset;
   logic        enable;
   logic        ser_in;
   logic [7:0]  sr_data;
   logic        frame_clr;
   logic        rd_en;
   logic [7:0]  rd_data;
   logic        empty;
   logic        full;
   logic [AW:0] level;
   logic        overflow;
   logic        ovf_clr;
   logic [2:0]  bit_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: byte queue, slot count, sticky flag, upstream shift register.
   logic [7:0] m_q[$];
   int         m_cnt;
   logic       m_ovf;
   logic [7:0] m_sr;

   serial_byte_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
      .inv_serclk (inv_serclk),
      .reset      (reset),
      .enable     (enable),
      .ser_in     (ser_in),
      .sr_data    (sr_data),
      .frame_clr  (frame_clr),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .empty      (empty),
      .full       (full),
      .level      (level),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .bit_cnt    (bit_cnt)
   );

   initial begin
      inv_serclk = 1'b0;
      forever #5 inv_serclk = ~inv_serclk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".bit_cnt"},  32'(bit_cnt),  32'(m_cnt));
      chk({tag, ".level"},    32'(level),    32'(m_q.size()));
      chk({tag, ".empty"},    32'(empty),    32'(m_q.size() == 0));
      chk({tag, ".full"},     32'(full),     32'(m_q.size() == DEPTH));
      chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      chk({tag, ".rd_data"},  32'(rd_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_sr    = 8'h00;
      sr_data = 8'h00;
   endtask

   // One clock: inputs applied after the previous edge, outputs checked 1 ns after this edge.
   task automatic step(input string tag, input logic en, input logic b, input logic fc,
                       input logic rd, input logic oc);
      logic drop;
      enable = en; ser_in = b; frame_clr = fc; rd_en = rd; ovf_clr = oc;
      drop = 1'b0;
      if (rd && m_q.size() > 0)
         m_q.delete(0);
      if (en && !fc && m_cnt == 7) begin
         if (m_q.size() < DEPTH)
            m_q.push_back({m_sr[6:0], b});
         else
            drop = 1'b1;
      end
      if (fc)
         m_cnt = 0;
      else if (en)
         m_cnt = (m_cnt + 1) % 8;
      if (drop)
         m_ovf = 1'b1;
      else if (oc)
         m_ovf = 1'b0;
      if (en)
         m_sr = {m_sr[6:0], b};
      @(posedge inv_serclk);
      #1;
      sr_data = m_sr;
      enable = 1'b0; frame_clr = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
      check_all(tag);
   endtask

   task automatic send_byte(input string tag, input logic [7:0] v, input logic rd_last,
                            input logic oc_last);
      for (int i = 7; i >= 0; i--)
         step(tag, 1'b1, v[i], 1'b0, (i == 0) ? rd_last : 1'b0, (i == 0) ? oc_last : 1'b0);
   endtask

   task automatic send_bits(input string tag, input logic [7:0] v, input int n);
      for (int i = 7; i > 7 - n; i--)
         step(tag, 1'b1, v[i], 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < DEPTH + 1; i++)
         pop(tag);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; ser_in = 1'b0; frame_clr = 1'b0;
      rd_en = 1'b0; ovf_clr = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      #2 reset = 1'b0;
      @(posedge inv_serclk);
      #1;

      // 1: single byte, bit counter walks 1..7,0
      send_byte("t1_a5", 8'hA5, 1'b0, 1'b0);
      chk("t1_rd_data", 32'(rd_data), 32'hA5);
      pop("t1_pop");

      // 2: fill, then drop the fifth byte
      send_byte("t2_11", 8'h11, 1'b0, 1'b0);
      send_byte("t2_22", 8'h22, 1'b0, 1'b0);
      send_byte("t2_33", 8'h33, 1'b0, 1'b0);
      send_byte("t2_44", 8'h44, 1'b0, 1'b0);
      send_byte("t2_55", 8'h55, 1'b0, 1'b0);
      chk("t2_full", 32'(full), 32'h1);
      chk("t2_ovf", 32'(overflow), 32'h1);
      drain("t2_drain");
      step("t2_ovfclr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 3: full FIFO, pop on the completing edge keeps the byte
      send_byte("t3_11", 8'h11, 1'b0, 1'b0);
      send_byte("t3_22", 8'h22, 1'b0, 1'b0);
      send_byte("t3_33", 8'h33, 1'b0, 1'b0);
      send_byte("t3_44", 8'h44, 1'b0, 1'b0);
      send_byte("t3_66", 8'h66, 1'b1, 1'b0);
      chk("t3_level", 32'(level), 32'd4);
      chk("t3_ovf", 32'(overflow), 32'h0);
      drain("t3_drain");

      // 4: frame_clr alone, then frame_clr together with enable
      send_bits("t4_part", 8'hFF, 3);
      step("t4_clr", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_cnt0", 32'(bit_cnt), 32'h0);
      send_byte("t4_3c", 8'h3C, 1'b0, 1'b0);
      chk("t4_level", 32'(level), 32'd1);
      drain("t4_drain");
      send_bits("t4b_part", 8'h00, 3);
      step("t4b_clr_en", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4b_cnt0", 32'(bit_cnt), 32'h0);
      send_byte("t4b_3c", 8'h3C, 1'b0, 1'b0);
      chk("t4b_rd", 32'(rd_data), 32'h3C);
      drain("t4b_drain");

      // 5: asynchronous reset in the middle of a clock period
      send_byte("t5_pre", 8'h5A, 1'b0, 1'b0);
      send_bits("t5_part", 8'hF0, 5);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check_all("t5_async");
      #2 reset = 1'b0;
      @(posedge inv_serclk);
      #1;
      check_all("t5_post");
      send_byte("t5_81", 8'h81, 1'b0, 1'b0);
      chk("t5_level", 32'(level), 32'd1);
      drain("t5_drain");

      // 6: set beats clear, plain clear, pop while empty
      for (int i = 0; i < DEPTH + 1; i++)
         send_byte("t6_fill", 8'(8'h70 + i), 1'b0, 1'b0);
      send_byte("t6_dropclr", 8'h99, 1'b0, 1'b1);
      chk("t6_ovf_kept", 32'(overflow), 32'h1);
      step("t6_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_ovf_clr", 32'(overflow), 32'h0);
      drain("t6_drain");
      pop("t6_empty_pop");
      chk("t6_level0", 32'(level), 32'h0);

      // Random traffic
      for (int i = 0; i < 600; i++)
         step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 31) == 0),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 15) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
